// File: rtl/ad_ip_jesd204_tpl_adc_capture_ctrl_if.sv
// Sample stream bundle around the TPL ADC capture controller:
// deframer beats in, DMA-facing per-channel valid/data out.
interface ad_ip_jesd204_tpl_adc_capture_ctrl_if #(
   parameter int NUM_CHANNELS    = 4,
   parameter int DATA_PATH_WIDTH = 2,
   parameter int BITS_PER_SAMPLE = 16,
   parameter int OCTETS_PER_BEAT = 4
);
   localparam int DATA_W = NUM_CHANNELS * DATA_PATH_WIDTH * BITS_PER_SAMPLE;

   logic                       in_valid;
   logic [OCTETS_PER_BEAT-1:0] in_sof;
   logic [DATA_W-1:0]          in_data;
   logic [NUM_CHANNELS-1:0]    adc_valid;
   logic [DATA_W-1:0]          adc_data;

   modport master (output in_valid, in_sof, in_data, input adc_valid, adc_data);
   modport slave  (input in_valid, in_sof, in_data, output adc_valid, adc_data);
endinterface

// File: rtl/ad_ip_jesd204_tpl_adc_capture_ctrl.sv
// TPL ADC capture/sync controller: SOF-aligned, length-limited capture with optional
// continuous re-arm. Define ADC_CAPTURE_TIMEOUT_EN to add the ARMED/ALIGN timeout.
module ad_ip_jesd204_tpl_adc_capture_ctrl #(
   parameter int          NUM_CHANNELS      = 4,
   parameter int          DATA_PATH_WIDTH   = 2,
   parameter int          BITS_PER_SAMPLE   = 16,
   parameter int          OCTETS_PER_BEAT   = 4,
   parameter int          CAPTURE_CNT_WIDTH = 16,
   parameter int unsigned TIMEOUT_CYCLES    = 65535
) (
   input  logic                          clk,
   input  logic                          rst,
   ad_ip_jesd204_tpl_adc_capture_ctrl_if.slave bus,
   input  logic [NUM_CHANNELS-1:0]       enable,
   input  logic                          arm,
   input  logic                          abort,
   input  logic                          ext_sync_en,
   input  logic                          sync_in,
   input  logic                          continuous,
   input  logic [CAPTURE_CNT_WIDTH-1:0]  capture_len,
   output logic                          sync_status,
   output logic                          capture_done,
   output logic                          underrun,
   output logic [2:0]                    fsm_debug,
`ifdef ADC_CAPTURE_TIMEOUT_EN
   output logic                          timeout,
`endif
   output logic [31:0]                   counter_debug
);

   localparam int DATA_W = NUM_CHANNELS * DATA_PATH_WIDTH * BITS_PER_SAMPLE;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ARMED   = 3'd1;
   localparam logic [2:0] ST_ALIGN   = 3'd2;
   localparam logic [2:0] ST_CAPTURE = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;
   localparam logic [2:0] ST_TIMEOUT = 3'd5;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   logic                          sync_meta_q, sync_s_q, sync_prev_q;
   logic                          sync_edge;
   logic [2:0]                    state_q, state_d;
   logic [CAPTURE_CNT_WIDTH-1:0]  len_q, len_d;
   logic [CAPTURE_CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d, beat_next;
   logic [31:0]                   dbg_cnt_q, dbg_cnt_d;
   logic                          underrun_q, underrun_d;
   logic                          capture, last_beat;
   logic [NUM_CHANNELS-1:0]       adc_valid_q;
   logic [DATA_W-1:0]             adc_data_q;
`ifdef ADC_CAPTURE_TIMEOUT_EN
   logic [31:0]                   to_cnt_q, to_cnt_d;
   logic                          timeout_q, timeout_d;
   logic                          to_hit;
`endif

   // sync_in metastability pair plus a delayed copy for rising-edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_meta_q <= 1'b0;
         sync_s_q    <= 1'b0;
         sync_prev_q <= 1'b0;
      end else begin
         sync_meta_q <= sync_in;
         sync_s_q    <= sync_meta_q;
         sync_prev_q <= sync_s_q;
      end
   end

   assign sync_edge = sync_s_q & ~sync_prev_q;
   assign beat_next = beat_cnt_q + 1'b1;
   // Length 0 never matches, so an unlimited capture only ends on abort.
   assign last_beat = (len_q != '0) && (beat_next == len_q);

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      beat_cnt_d = beat_cnt_q;
      dbg_cnt_d  = dbg_cnt_q;
      underrun_d = underrun_q;
      capture    = 1'b0;
`ifdef ADC_CAPTURE_TIMEOUT_EN
      to_cnt_d   = to_cnt_q;
      timeout_d  = timeout_q;
      to_hit     = (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`endif
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (arm) begin
                  state_d    = ST_ARMED;
                  len_d      = capture_len;
                  beat_cnt_d = '0;
                  dbg_cnt_d  = '0;
                  underrun_d = 1'b0;
`ifdef ADC_CAPTURE_TIMEOUT_EN
                  to_cnt_d   = '0;
                  timeout_d  = 1'b0;
`endif
               end
            end
            ST_ARMED: begin
`ifdef ADC_CAPTURE_TIMEOUT_EN
               if (to_hit) begin
                  state_d   = ST_TIMEOUT;
                  timeout_d = 1'b1;
               end else begin
                  to_cnt_d = to_cnt_q + 32'd1;
                  if (!ext_sync_en || sync_edge) state_d = ST_ALIGN;
               end
`else
               if (!ext_sync_en || sync_edge) state_d = ST_ALIGN;
`endif
            end
            ST_ALIGN: begin
               if (bus.in_valid && bus.in_sof[0]) begin
                  capture = 1'b1;
                  state_d = ST_CAPTURE;
`ifdef ADC_CAPTURE_TIMEOUT_EN
               end else if (to_hit) begin
                  state_d   = ST_TIMEOUT;
                  timeout_d = 1'b1;
               end else begin
                  to_cnt_d = to_cnt_q + 32'd1;
`endif
               end
            end
            ST_CAPTURE: begin
               if (bus.in_valid) capture = 1'b1;
               else              underrun_d = 1'b1;
            end
            default: state_d = ST_IDLE;
         endcase

         // Beat accounting shared by the first (SOF) beat and the following ones
         if (capture) begin
            beat_cnt_d = beat_next;
            dbg_cnt_d  = sat_inc32(dbg_cnt_q);
            if (last_beat) begin
               if (continuous) begin
                  state_d    = ST_ARMED;
                  len_d      = capture_len;
                  beat_cnt_d = '0;
`ifdef ADC_CAPTURE_TIMEOUT_EN
                  to_cnt_d   = '0;
`endif
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         beat_cnt_q  <= '0;
         dbg_cnt_q   <= '0;
         underrun_q  <= 1'b0;
         adc_valid_q <= '0;
         adc_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         beat_cnt_q  <= beat_cnt_d;
         dbg_cnt_q   <= dbg_cnt_d;
         underrun_q  <= underrun_d;
         adc_valid_q <= capture ? enable : '0;
         if (capture) adc_data_q <= bus.in_data;
      end
   end

`ifdef ADC_CAPTURE_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         to_cnt_q  <= to_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`endif

   assign bus.adc_valid  = adc_valid_q;
   assign bus.adc_data   = adc_data_q;
   assign fsm_debug      = state_q;
   assign sync_status    = (state_q == ST_ARMED) || (state_q == ST_ALIGN);
   assign capture_done   = (state_q == ST_DONE);
   assign underrun       = underrun_q;
   assign counter_debug  = dbg_cnt_q;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_capture_ctrl.sv
// Directed bench for the TPL ADC capture controller (default build; timeout steps
// are included when ADC_CAPTURE_TIMEOUT_EN is defined).
module tb_ad_ip_jesd204_tpl_adc_capture_ctrl;

   localparam int NCH = 4;
   localparam int DW  = NCH * 2 * 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [NCH-1:0] enable;
   logic        arm, abort, ext_sync_en, sync_in, continuous;
   logic [15:0] capture_len;
   logic        sync_status, capture_done, underrun;
   logic [2:0]  fsm_debug;
   logic [31:0] counter_debug;
`ifdef ADC_CAPTURE_TIMEOUT_EN
   logic        timeout;
`endif

   int checks = 0;
   int errors = 0;

   ad_ip_jesd204_tpl_adc_capture_ctrl_if #(
      .NUM_CHANNELS(NCH), .DATA_PATH_WIDTH(2), .BITS_PER_SAMPLE(16), .OCTETS_PER_BEAT(4)
   ) bus ();

   ad_ip_jesd204_tpl_adc_capture_ctrl #(
      .NUM_CHANNELS(NCH), .DATA_PATH_WIDTH(2), .BITS_PER_SAMPLE(16), .OCTETS_PER_BEAT(4),
      .CAPTURE_CNT_WIDTH(16), .TIMEOUT_CYCLES(100)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .enable(enable), .arm(arm), .abort(abort),
      .ext_sync_en(ext_sync_en), .sync_in(sync_in), .continuous(continuous),
      .capture_len(capture_len), .sync_status(sync_status), .capture_done(capture_done),
      .underrun(underrun), .fsm_debug(fsm_debug),
`ifdef ADC_CAPTURE_TIMEOUT_EN
      .timeout(timeout),
`endif
      .counter_debug(counter_debug)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] pat(input int k);
      return {32'hDEAD_0000 + k, 32'hBEEF_0000 + k, 32'h1234_0000 + k, 32'h0F0F_0000 + k};
   endfunction

   initial begin
      int vcnt, dcnt, done_at;
      bit [8:0] vpat;

      rst = 1'b1; enable = '0; arm = 0; abort = 0; ext_sync_en = 0; sync_in = 0;
      continuous = 0; capture_len = '0;
      bus.in_valid = 0; bus.in_sof = '0; bus.in_data = '0;
      tick(); tick();
      chk("rst_fsm", fsm_debug, 0);
      chk("rst_valid", bus.adc_valid, 0);
      chk("rst_data", bus.adc_data, 0);
      chk("rst_misc", {sync_status, capture_done, underrun}, 0);
      chk("rst_cnt", counter_debug, 0);
`ifdef ADC_CAPTURE_TIMEOUT_EN
      chk("rst_timeout", timeout, 0);
`endif
      rst = 1'b0;
      tick();

      // Basic capture: len 4, enable 0101, SOF on third valid beat
      capture_len = 16'd4; enable = 4'b0101;
      arm = 1; tick(); arm = 0;
      chk("basic_armed", fsm_debug, 1);
      chk("basic_sync_status", sync_status, 1);
      bus.in_valid = 1; bus.in_sof = 4'b0000; bus.in_data = pat(100);
      tick();
      chk("basic_align", fsm_debug, 2);
      chk("basic_novalid1", bus.adc_valid, 0);
      bus.in_data = pat(101);
      tick();
      chk("basic_novalid2", bus.adc_valid, 0);
      for (int k = 0; k < 4; k++) begin
         bus.in_sof = (k == 0) ? 4'b0001 : 4'b0000;
         bus.in_data = pat(k);
         tick();
         chk("basic_valid", bus.adc_valid, 4'b0101);
         chk("basic_data", bus.adc_data, pat(k));
         chk("basic_done", capture_done, (k == 3));
         chk("basic_state", fsm_debug, (k == 3) ? 3'd4 : 3'd3);
      end
      bus.in_valid = 0; bus.in_sof = '0;
      tick();
      chk("basic_idle", fsm_debug, 0);
      chk("basic_done_once", capture_done, 0);
      chk("basic_valid_off", bus.adc_valid, 0);
      chk("basic_data_hold", bus.adc_data, pat(3));
      chk("basic_count", counter_debug, 4);

      // External sync: edge reaches the FSM 3 edges after the pin rises
      ext_sync_en = 1; capture_len = 16'd2; enable = 4'b1111;
      arm = 1; tick(); arm = 0;
      bus.in_valid = 1; bus.in_sof = 4'b0001; bus.in_data = pat(200);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("sync_wait_state", fsm_debug, 1);
         chk("sync_wait_valid", bus.adc_valid, 0);
      end
      sync_in = 1;
      tick();
      chk("sync_e1", fsm_debug, 1);
      tick();
      chk("sync_e2", fsm_debug, 1);
      tick();
      chk("sync_e3_align", fsm_debug, 2);
      chk("sync_e3_status", sync_status, 1);
      chk("sync_e3_novalid", bus.adc_valid, 0);
      bus.in_data = pat(201);
      tick();
      chk("sync_cap_state", fsm_debug, 3);
      chk("sync_cap_valid", bus.adc_valid, 4'b1111);
      chk("sync_cap_data", bus.adc_data, pat(201));
      chk("sync_cap_status", sync_status, 0);
      tick();
      chk("sync_done", capture_done, 1);
      tick();
      chk("sync_idle", fsm_debug, 0);
      chk("sync_count", counter_debug, 2);
      sync_in = 0; ext_sync_en = 0;

      // Continuous, len 3, two rounds, one dropped beat in round 1
      continuous = 1; capture_len = 16'd3; enable = 4'b0011;
      arm = 1; tick(); arm = 0;
      bus.in_sof = 4'b0001;
      vpat = 9'b1_1111_1011;
      vcnt = 0; dcnt = 0;
      for (int i = 0; i < 9; i++) begin
         bus.in_valid = vpat[i];
         tick();
         if (bus.adc_valid === 4'b0011) vcnt++;
         if (capture_done === 1'b1) dcnt++;
         if (i == 4) chk("cont_rearm1", fsm_debug, 1);
      end
      chk("cont_rearm2", fsm_debug, 1);
      bus.in_valid = 1;
      abort = 1; tick(); abort = 0;
      if (bus.adc_valid === 4'b0011) vcnt++;
      if (capture_done === 1'b1) dcnt++;
      chk("cont_abort_idle", fsm_debug, 0);
      chk("cont_beats", vcnt, 6);
      chk("cont_no_done", dcnt, 0);
      chk("cont_underrun", underrun, 1);
      chk("cont_count", counter_debug, 6);
      continuous = 0;

      // Abort and arm together during an unlimited capture
      capture_len = 16'd0; enable = 4'b1111;
      arm = 1; tick(); arm = 0;
      chk("abort_underrun_clr", underrun, 0);
      tick();
      bus.in_data = pat(300);
      tick();
      bus.in_data = pat(301);
      tick();
      chk("abort_capturing", fsm_debug, 3);
      abort = 1; arm = 1; bus.in_data = pat(302);
      tick();
      abort = 0; arm = 0;
      chk("abort_state", fsm_debug, 0);
      chk("abort_valid", bus.adc_valid, 0);
      chk("abort_data", bus.adc_data, pat(301));
      tick();
      chk("abort_arm_ignored", fsm_debug, 0);
      chk("abort_valid2", bus.adc_valid, 0);
      chk("abort_count", counter_debug, 2);

      // Asynchronous reset at beat 2 of 8
      capture_len = 16'd8;
      arm = 1; tick(); arm = 0;
      tick();
      bus.in_data = pat(400); tick();
      bus.in_data = pat(401); tick();
      chk("rstmid_capturing", bus.adc_valid, 4'b1111);
      #2 rst = 1;
      #1;
      chk("rstmid_state", fsm_debug, 0);
      chk("rstmid_valid", bus.adc_valid, 0);
      chk("rstmid_data", bus.adc_data, 0);
      chk("rstmid_cnt", counter_debug, 0);
      chk("rstmid_flags", {sync_status, capture_done, underrun}, 0);
      tick();
      rst = 0;
      tick();
      chk("rstmid_no_done", capture_done, 0);

      // Single-beat capture after reset
      capture_len = 16'd1; enable = 4'b1010;
      arm = 1; tick(); arm = 0;
      chk("len1_armed", fsm_debug, 1);
      tick();
      bus.in_data = pat(500);
      tick();
      chk("len1_done_state", fsm_debug, 4);
      chk("len1_done", capture_done, 1);
      chk("len1_valid", bus.adc_valid, 4'b1010);
      chk("len1_data", bus.adc_data, pat(500));
      tick();
      chk("len1_idle", fsm_debug, 0);
      chk("len1_count", counter_debug, 1);

      // Maximum length: exactly 65535 beats, no counter wrap
      capture_len = 16'hFFFF; enable = 4'b0001;
      arm = 1; tick(); arm = 0;
      tick();
      vcnt = 0; done_at = -1;
      for (int i = 0; i < 70000; i++) begin
         tick();
         if (bus.adc_valid !== 4'b0000) vcnt++;
         if (capture_done === 1'b1) begin
            done_at = vcnt;
            break;
         end
      end
      chk("max_done_beat", done_at, 65535);
      chk("max_count", counter_debug, 65535);
      tick();
      chk("max_idle", fsm_debug, 0);
      bus.in_valid = 0;

`ifdef ADC_CAPTURE_TIMEOUT_EN
      ext_sync_en = 1; sync_in = 0;
      arm = 1; tick(); arm = 0;
      vcnt = 0;
      while (timeout !== 1'b1 && vcnt < 300) begin
         tick();
         vcnt++;
      end
      chk("to_cycles", vcnt, 100);
      chk("to_state", fsm_debug, 5);
      tick();
      chk("to_idle", fsm_debug, 0);
      chk("to_no_done", capture_done, 0);
      chk("to_sticky", timeout, 1);
      ext_sync_en = 0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
